// File: rtl/ex_vector_unit.sv
// EX-stage vector unit: scalar ALU ops, lane-wise vector ops and a DIMxDIM tile matrix
// multiply. Sits between the ID/EX operand registers and the EX/MEM register, with a
// valid/ready handshake on both sides so the pipeline can stall while a MATMUL runs.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake; an op is accepted when both are high on an edge
//   rs1_val            operand A
//   rs2_val / imm      operand B, selected by use_imm
//   alu_ctrl           4-bit opcode
//   out_valid/out_ready result handshake
//   alu_result         registered result, held stable while out_valid is high
//   illegal_op         registered; high with out_valid when the accepted opcode was undefined
//   busy               high while a MATMUL is being computed
module ex_vector_unit #(
  parameter int unsigned DIM      = 2,
  parameter int unsigned LANE_W   = 8,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned LANES   = DIM * DIM,
  localparam int unsigned XLEN    = LANES * LANE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            illegal_op,
  output logic            busy
);

  // Dot-product accumulator wide enough that DIM full-scale products never overflow.
  localparam int unsigned ProdW = 2 * LANE_W + $clog2(DIM);
  localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] OpAdd    = 4'h0;
  localparam logic [3:0] OpSub    = 4'h1;
  localparam logic [3:0] OpAnd    = 4'h2;
  localparam logic [3:0] OpOr     = 4'h3;
  localparam logic [3:0] OpXor    = 4'h4;
  localparam logic [3:0] OpRelu   = 4'h8;
  localparam logic [3:0] OpMatmul = 4'h9;
  localparam logic [3:0] OpVecadd = 4'hA;
  localparam logic [3:0] OpMpool  = 4'hB;
  localparam logic [3:0] OpVrelu  = 4'hC;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   opa_q, opb_q;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;

  logic [XLEN-1:0]   op_a, op_b;
  logic              accept, is_matmul, cnt_last;
  logic [XLEN-1:0]   sc_result;
  logic              sc_illegal;
  logic [LANE_W:0]   lane_sum;
  logic [LANE_W-1:0] lane_max;
  logic [ProdW-1:0]  mm_acc;
  logic [LANE_W-1:0] mm_elem;
  int unsigned       mm_row, mm_col;

  assign op_a      = rs1_val;
  assign op_b      = use_imm ? imm : rs2_val;
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_matmul = (alu_ctrl == OpMatmul);
  assign cnt_last  = (cnt_q == CntW'(LANES - 1));

  // Single-cycle ops are evaluated straight from the operands being captured so the
  // result can be registered on the accept edge.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    lane_sum   = '0;
    lane_max   = op_a[LANE_W-1:0];
    case (alu_ctrl)
      OpAdd:    sc_result = op_a + op_b;
      OpSub:    sc_result = op_a - op_b;
      OpAnd:    sc_result = op_a & op_b;
      OpOr:     sc_result = op_a | op_b;
      OpXor:    sc_result = op_a ^ op_b;
      OpRelu:   sc_result = op_a[XLEN-1] ? '0 : op_a;
      OpMatmul: sc_result = '0;
      OpVecadd: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          lane_sum = {1'b0, op_a[i*LANE_W +: LANE_W]} + {1'b0, op_b[i*LANE_W +: LANE_W]};
          if (SATURATE && lane_sum[LANE_W]) begin
            sc_result[i*LANE_W +: LANE_W] = '1;
          end else begin
            sc_result[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
          end
        end
      end
      OpMpool: begin
        for (int unsigned i = 1; i < LANES; i++) begin
          if ($signed(op_a[i*LANE_W +: LANE_W]) > $signed(lane_max)) begin
            lane_max = op_a[i*LANE_W +: LANE_W];
          end
        end
        // A negative maximum reports as zero.
        if (!lane_max[LANE_W-1]) sc_result[LANE_W-1:0] = lane_max;
      end
      OpVrelu: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (!op_a[i*LANE_W+LANE_W-1]) begin
            sc_result[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W];
          end
        end
      end
      default:  sc_illegal = 1'b1;
    endcase
  end

  // One output element per cycle: element cnt is (row, col) = (cnt / DIM, cnt % DIM).
  always_comb begin
    mm_acc = '0;
    mm_row = 32'(cnt_q) / DIM;
    mm_col = 32'(cnt_q) % DIM;
    for (int unsigned k = 0; k < DIM; k++) begin
      mm_acc = mm_acc + ProdW'(opa_q[(mm_row*DIM+k)*LANE_W +: LANE_W])
                      * ProdW'(opb_q[(k*DIM+mm_col)*LANE_W +: LANE_W]);
    end
    if (SATURATE && (|mm_acc[ProdW-1:LANE_W])) begin
      mm_elem = '1;
    end else begin
      mm_elem = mm_acc[LANE_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = is_matmul ? StBusy : StDone;
      StBusy: if (cnt_last) state_d = StDone;
      StDone: begin
        if (out_ready) state_d = accept ? (is_matmul ? StBusy : StDone) : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q <= op_a;
        opb_q <= op_b;
        if (is_matmul) begin
          // Unwritten lanes read as zero while the tile fills in.
          result_q  <= '0;
          illegal_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          result_q  <= sc_result;
          illegal_q <= sc_illegal;
        end
      end else if (state_q == StBusy) begin
        result_q[cnt_q*LANE_W +: LANE_W] <= mm_elem;
        cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StBusy);
  assign alu_result = result_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_ex_vector_unit.sv
// Bench for ex_vector_unit: two instances (wrapping and saturating) share one stimulus
// stream. A table of vectors plus hand-written stall, streaming and reset sequences; each
// accepted op pushes its expected result to a queue that a monitor pops on handoff.
module tb_ex_vector_unit;

  localparam int unsigned LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic        use_imm = 1'b0;
  logic [3:0]  alu_ctrl = '0;

  logic        in_ready0, out_valid0, illegal0, busy0;
  logic        in_ready1, out_valid1, illegal1, busy1;
  logic [31:0] alu_result0, alu_result1;

  ex_vector_unit #(.DIM(2), .LANE_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .use_imm(use_imm),
    .alu_ctrl(alu_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .alu_result(alu_result0), .illegal_op(illegal0), .busy(busy0)
  );

  ex_vector_unit #(.DIM(2), .LANE_W(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .use_imm(use_imm),
    .alu_ctrl(alu_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .alu_result(alu_result1), .illegal_op(illegal1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, im;
    logic        ui;
    logic [31:0] e0, e1;
    logic        ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e0, e1;
    logic        ill;
    int          cyc;
    bit          chk;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  sb_t  mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic ui,
                              input logic [31:0] e0, input logic [31:0] e1, input logic ill);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.im = im; v.ui = ui;
    v.e0 = e0; v.e1 = e1; v.ill = ill;
    return v;
  endfunction

  // Scoreboard monitor: compares every handed-off result against the oldest pending op.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%08h with no op pending", alu_result0);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, alu_result0, mon_e.e0);
        check({mon_e.name, "_result_sat"}, alu_result1, mon_e.e1);
        check({mon_e.name, "_illegal"}, {31'd0, illegal0}, {31'd0, mon_e.ill});
        check({mon_e.name, "_illegal_sat"}, {31'd0, illegal1}, {31'd0, mon_e.ill});
        check({mon_e.name, "_valid_sat"}, {31'd0, out_valid1}, 32'd1);
        if (mon_e.chk) check({mon_e.name, "_latency"}, cyc, mon_e.cyc);
      end
    end
  end

  // Drive one op and hold it until accepted; push its expectation at the accepting edge.
  task automatic issue(input vec_t v, input bit chk, output int waited);
    sb_t e;
    rs1_val  = v.a;
    rs2_val  = v.b;
    imm      = v.im;
    use_imm  = v.ui;
    alu_ctrl = v.op;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept_timeout: in_ready=%0b, expected 1", v.name, in_ready0);
    end else begin
      e.name = v.name; e.e0 = v.e0; e.e1 = v.e1; e.ill = v.ill; e.chk = chk;
      e.cyc  = cyc + 1 + ((v.op == 4'h9) ? LANES : 0);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d results pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    vec_t        mm1, addv, xv;
    logic [31:0] partial [4];
    logic [31:0] xa [3];
    logic [31:0] xb [3];

    mm1  = mk("mm_stall", 4'h9, 32'h04030201, 32'h08070605, 32'h0, 1'b0,
              32'h322B1613, 32'h322B1613, 1'b0);
    addv = mk("add_after_rst", 4'h0, 32'h5, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h4, 32'h4, 1'b0);

    vecs.push_back(mk("add_imm", 4'h0, 32'h5, 32'h12345678, 32'hFFFFFFFF, 1'b1,
                      32'h4, 32'h4, 1'b0));
    vecs.push_back(mk("sub", 4'h1, 32'h5, 32'h6, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("and", 4'h2, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 1'b0,
                      32'h30303030, 32'h30303030, 1'b0));
    vecs.push_back(mk("or", 4'h3, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 1'b0,
                      32'hFCFCFCFC, 32'hFCFCFCFC, 1'b0));
    vecs.push_back(mk("xor", 4'h4, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 1'b0,
                      32'hCCCCCCCC, 32'hCCCCCCCC, 1'b0));
    vecs.push_back(mk("relu_neg", 4'h8, 32'h80000000, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk("relu_pos", 4'h8, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0,
                      32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0));
    vecs.push_back(mk("mm_basic", 4'h9, 32'h04030201, 32'h08070605, 32'h0, 1'b0,
                      32'h322B1613, 32'h322B1613, 1'b0));
    vecs.push_back(mk("mm_full", 4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0,
                      32'h02020202, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("mm_partial_sat", 4'h9, 32'h00001010, 32'h00001010, 32'h0, 1'b0,
                      32'h00000000, 32'h0000FFFF, 1'b0));
    vecs.push_back(mk("mm_identity", 4'h9, 32'h01000001, 32'h44332211, 32'h0, 1'b0,
                      32'h44332211, 32'h44332211, 1'b0));
    vecs.push_back(mk("vecadd", 4'hA, 32'h80FF0102, 32'h80010203, 32'h0, 1'b0,
                      32'h00000305, 32'hFFFF0305, 1'b0));
    vecs.push_back(mk("vecadd_imm", 4'hA, 32'h01010101, 32'hFFFFFFFF, 32'h02020202, 1'b1,
                      32'h03030303, 32'h03030303, 1'b0));
    vecs.push_back(mk("mpool", 4'hB, 32'hF0FE0380, 32'h0, 32'h0, 1'b0, 32'h3, 32'h3, 1'b0));
    vecs.push_back(mk("mpool_allneg", 4'hB, 32'h80FFFEF0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk("mpool_top", 4'hB, 32'h7F010203, 32'h0, 32'h0, 1'b0, 32'h7F, 32'h7F, 1'b0));
    vecs.push_back(mk("vrelu", 4'hC, 32'h80017FFF, 32'h0, 32'h0, 1'b0,
                      32'h00017F00, 32'h00017F00, 1'b0));
    vecs.push_back(mk("illegal_7", 4'h7, 32'h12345678, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("illegal_f", 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0,
                      32'h0, 32'h0, 1'b1));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_result", alu_result0, 32'd0);
    check("rst_illegal", {31'd0, illegal0}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1, w);
      drain(vecs[i].name);
    end

    // MATMUL with the consumer stalled: lanes fill one per cycle, then the result holds.
    partial[0] = 32'h00000000;
    partial[1] = 32'h00000013;
    partial[2] = 32'h00001613;
    partial[3] = 32'h002B1613;
    out_ready = 1'b0;
    issue(mm1, 1'b0, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_busy", {31'd0, busy0}, 32'd1);
      check("stall_valid_low", {31'd0, out_valid0}, 32'd0);
      check("stall_partial", alu_result0, partial[i]);
    end
    @(negedge clk);
    check("stall_done_valid", {31'd0, out_valid0}, 32'd1);
    check("stall_done_busy", {31'd0, busy0}, 32'd0);
    check("stall_in_ready", {31'd0, in_ready0}, 32'd0);
    @(posedge clk);
    #1;
    rs1_val  = 32'h11111111;
    rs2_val  = 32'h22222222;
    use_imm  = 1'b0;
    alu_ctrl = 4'h0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_result", alu_result0, 32'h322B1613);
      check("hold_valid", {31'd0, out_valid0}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("stall");

    // Back-to-back XOR stream: one result per cycle, never a stall.
    xa[0] = 32'h0F0F0F0F; xb[0] = 32'h00FF00FF;
    xa[1] = 32'hAAAAAAAA; xb[1] = 32'h55555555;
    xa[2] = 32'h12345678; xb[2] = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      xv = mk("stream_xor", 4'h4, xa[i], xb[i], 32'h0, 1'b0, xa[i] ^ xb[i], xa[i] ^ xb[i], 1'b0);
      issue(xv, 1'b1, w);
      check("stream_no_stall", w, 0);
    end
    drain("stream");

    // Asynchronous reset two cycles into a MATMUL abandons it.
    issue(mm1, 1'b1, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    check("pre_rst_busy", {31'd0, busy0}, 32'd1);
    check("pre_rst_partial", alu_result0, 32'h00001613);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid0}, 32'd0);
    check("async_rst_busy", {31'd0, busy0}, 32'd0);
    check("async_rst_result", alu_result0, 32'd0);
    check("async_rst_result_sat", alu_result1, 32'd0);
    check("async_rst_illegal", {31'd0, illegal0}, 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(addv, 1'b1, w);
    drain("after_rst");
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
